// File: rtl/adder_exerciser_pkg.sv
// Shared types and sizes for the ripple-carry adder exerciser.
// Other adder benches reuse these definitions.
package adder_exerciser_pkg;

  localparam int VEC_W   = 9;
  localparam int SUM_W   = 5;
  localparam int ERR_W   = 10;
  localparam int NUM_VEC = 512;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    DONE
  } state_e;

endpackage

// File: rtl/adder_exerciser_ref_model.sv
// Golden model for a 4-bit adder.
// The vector layout is {c_in, b[3:0], a[3:0]}. The 5-bit sum keeps the carry out.
module adder_ref_model
  import adder_exerciser_pkg::*;
(
  input  logic [VEC_W-1:0] vec_i,
  output logic [SUM_W-1:0] exp_o
);

  assign exp_o = SUM_W'(vec_i[3:0]) + SUM_W'(vec_i[7:4]) + SUM_W'(vec_i[8]);

endmodule

// File: rtl/adder_exerciser.sv
// Exerciser for the 4-bit ripple_carry adder. It walks all 512 operand/carry combinations
// and counts the results that disagree with the golden sum.
module adder_exerciser
  import adder_exerciser_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sum1,
  input  logic             sum2,
  input  logic             sum3,
  input  logic             sum4,
  input  logic             c_out,
  output logic             a1,
  output logic             a2,
  output logic             a3,
  output logic             a4,
  output logic             b1,
  output logic             b2,
  output logic             b3,
  output logic             b4,
  output logic             c_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] first_fail
);

  localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);
  localparam logic [VEC_W-1:0] VEC_ONE  = VEC_W'(1);
  localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

  state_e           state_q;
  logic [VEC_W-1:0] vec_q;
  logic [VEC_W-1:0] failVec_q;
  logic [CNT_W-1:0] cnt_q;
  logic [ERR_W-1:0] errCount_q;
  logic [VEC_W-1:0] firstFail_q;
  logic             mismatchPend_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  logic [SUM_W-1:0] expSum;
  logic [SUM_W-1:0] obsSum;
  logic             mismatch;

  adder_ref_model u_ref (
    .vec_i (vec_q),
    .exp_o (expSum)
  );

  assign obsSum   = {c_out, sum4, sum3, sum2, sum1};
  assign mismatch = (obsSum != expSum);

  // The mismatch from a CHECK is booked one cycle later. The status outputs track
  // state_q with one cycle of lag, so done rises in the same cycle that err_count is final.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      vec_q          <= '0;
      failVec_q      <= '0;
      cnt_q          <= '0;
      errCount_q     <= '0;
      firstFail_q    <= '0;
      mismatchPend_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      pass_q         <= 1'b0;
    end else begin
      busy_q         <= (state_q == SETTLE) || (state_q == CHECK);
      done_q         <= (state_q == DONE);
      pass_q         <= (state_q == DONE) && (errCount_q == '0) && !mismatchPend_q;
      mismatchPend_q <= 1'b0;

      if (mismatchPend_q) begin
        errCount_q <= errCount_q + ERR_ONE;
        if (errCount_q == '0) begin
          firstFail_q <= failVec_q;
        end
      end

      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q     <= SETTLE;
            vec_q       <= '0;
            errCount_q  <= '0;
            firstFail_q <= '0;
            cnt_q       <= CNT_LOAD;
          end
        end
        SETTLE: begin
          if (cnt_q <= CNT_ONE) begin
            state_q <= CHECK;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        CHECK: begin
          mismatchPend_q <= mismatch;
          failVec_q      <= vec_q;
          if ((vec_q == LAST_VEC) || (STOP_ON_FAIL && mismatch)) begin
            state_q <= DONE;
          end else begin
            vec_q   <= vec_q + VEC_ONE;
            cnt_q   <= CNT_LOAD;
            state_q <= SETTLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign {a4, a3, a2, a1} = vec_q[3:0];
  assign {b4, b3, b2, b1} = vec_q[7:4];
  assign c_in             = vec_q[8];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = errCount_q;
  assign first_fail       = firstFail_q;

endmodule
